// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
// Serial bit-pattern transmitter. A PAT_W-bit pattern is sent MSB first, one
// bit per clock, repeat_cnt times, with gap_len idle cycles between
// repetitions. A single-cycle done pulse follows the last bit.
//
// Handshake: a request is accepted on the rising clock edge where
// start=1, ready=1 and abort=0. pattern, repeat_cnt and gap_len are sampled
// only on that edge. ready is high only in IDLE, and start is ignored at
// every other time.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   transfer request
//   pattern     in   PAT_W bits to send, bit PAT_W-1 first
//   repeat_cnt  in   number of pattern repetitions (0 = none, done only)
//   gap_len     in   idle cycles between repetitions
//   abort       in   synchronous cancel (SEND/GAP -> IDLE, no done)
//   ready       out  1 in IDLE (decoded from the state register)
//   out         out  serial data bit, registered, 0 when out_valid=0
//   out_valid   out  1 while out carries a pattern bit, registered
//   busy        out  1 in SEND or GAP, registered
//   done        out  single-cycle completion pulse, registered
//   dbg_state   out  raw FSM state for observation
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;     // repetitions still to finish
    logic [GAP_W-1:0] gap_q, gap_d;     // latched gap length
    logic [GAP_W-1:0] gcnt_q, gcnt_d;   // gap cycles left, including current
    logic [IDX_W-1:0] idx_q, idx_d;     // index of the bit currently on out
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] idx_m1;

    assign idx_m1 = idx_q - 1'b1;

    // Next-state and next-output logic. Outputs default to the idle values so
    // every path that does not explicitly send a bit drives out=0/out_valid=0.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_d = pattern;
                    rep_d = repeat_cnt;
                    gap_d = gap_len;
                    idx_d = IDX_MAX;
                    if (repeat_cnt != '0) begin
                        // First bit goes out on the acceptance edge itself.
                        state_d = SEND;
                        out_d   = pattern[PAT_W-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d   = idx_m1;
                    out_d   = pat_q[idx_m1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    // Last bit of this repetition is on out now.
                    rep_d = rep_q - 1'b1;
                    if (rep_q == CNT_ONE) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (gap_q == '0) begin
                        idx_d   = IDX_MAX;
                        out_d   = pat_q[PAT_W-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        gcnt_d  = gap_q;
                        busy_d  = 1'b1;
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gcnt_q == GAP_ONE) begin
                    state_d = SEND;
                    idx_d   = IDX_MAX;
                    out_d   = pat_q[PAT_W-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end

            DONE: begin
                // done pulse lasts one cycle; abort has no effect here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            idx_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
// Self-checking bench for seq_pattern_gen. Each transfer is compared cycle by
// cycle against a schedule computed from the pattern/repeat/gap arithmetic:
// bit k of the stream lies in period (k-1)/(PAT_W+G), and done appears in
// cycle R*PAT_W+(R-1)*G+1 (cycle 1 when R=0).
//
// Handshake: inputs change only on the falling clock edge; the DUT samples
// them on the next rising edge. Outputs are sampled on the falling edge as
// the packed vector {out, out_valid, busy, done, ready}.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             abort = 1'b0;
  logic             ready, out, out_valid, busy, done;
  logic [1:0]       dbg_state;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .abort      (abort),
    .ready      (ready),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int txn_id = 0;

  localparam logic [4:0] IDLE_V = 5'b00001;  // {out,valid,busy,done,ready}

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs();
    return {out, out_valid, busy, done, ready};
  endfunction

  // Reference schedule: expected outputs in cycle k after the acceptance edge.
  function automatic logic [4:0] model(input int k, input logic [PAT_W-1:0] pat,
                                       input int r, input int g, input int abort_at);
    int total;
    int per;
    int off;
    total = (r == 0) ? 1 : r * PAT_W + (r - 1) * g + 1;
    if (abort_at != 0 && k > abort_at) return IDLE_V;
    if (k < total) begin
      per = PAT_W + g;
      off = (k - 1) % per;
      if (off < PAT_W) return {pat[PAT_W-1-off], 1'b1, 1'b1, 1'b0, 1'b0};
      return 5'b00100;
    end
    if (k == total) return 5'b00010;
    return IDLE_V;
  endfunction

  // Driver: issue one request, then check every cycle until one idle cycle
  // after done (or after the abort). spurious re-asserts start with random
  // request fields while the DUT is not in IDLE.
  task automatic run_txn(input logic [PAT_W-1:0] pat, input int r, input int g,
                         input int abort_at, input bit spurious, input bit zero_spur);
    int total;
    int end_cycle;
    txn_id++;
    total = (r == 0) ? 1 : r * PAT_W + (r - 1) * g + 1;
    end_cycle = (abort_at != 0 && abort_at < total) ? abort_at + 1 : total + 1;
    check_val($sformatf("t%0d_pre", txn_id), {27'b0, obs()}, {27'b0, IDLE_V});
    pattern    = pat;
    repeat_cnt = CNT_W'(r);
    gap_len    = GAP_W'(g);
    start      = 1'b1;
    abort      = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= end_cycle; k++) begin
      check_val($sformatf("t%0d_c%0d", txn_id, k), {27'b0, obs()},
                {27'b0, model(k, pat, r, g, abort_at)});
      start = 1'b0;
      abort = (k == abort_at);
      if (spurious && k <= total && (abort_at == 0 || k <= abort_at)) begin
        start      = 1'($urandom_range(0, 1));
        pattern    = zero_spur ? '0 : PAT_W'($urandom);
        repeat_cnt = CNT_W'($urandom);
        gap_len    = GAP_W'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    logic [PAT_W-1:0] rp;
    int rr, rg, ra, tot;

    // reset state
    #1 rst_n = 1'b0;
    #1 check_val("reset_hold", {27'b0, obs()}, {27'b0, IDLE_V});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("reset_release", {27'b0, obs()}, {27'b0, IDLE_V});

    // directed cases
    run_txn(4'b1101, 1, 0, 0, 1'b0, 1'b0);   // single send
    run_txn(4'b1101, 3, 0, 0, 1'b0, 1'b0);   // back-to-back
    run_txn(4'b1101, 2, 2, 0, 1'b0, 1'b0);   // with gap
    run_txn(4'b1010, 0, 3, 0, 1'b0, 1'b0);   // zero repeat
    run_txn(4'b1011, 2, 1, 0, 1'b1, 1'b1);   // ignored start (pattern 0000)
    run_txn(4'b1101, 2, 1, 3, 1'b0, 1'b0);   // abort on 3rd bit
    run_txn(4'b0111, 1, 0, 5, 1'b0, 1'b0);   // abort during done pulse
    run_txn(4'b1001, 15, 0, 0, 1'b0, 1'b0);  // max repeat count

    // abort with simultaneous start in IDLE
    pattern = 4'b1111; repeat_cnt = 4'd2; gap_len = 4'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_val("abort_start_c1", {27'b0, obs()}, {27'b0, IDLE_V});
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_val("abort_start_c2", {27'b0, obs()}, {27'b0, IDLE_V});

    // reset during GAP (cycles 5..7 of a 1101 r=2 g=3 transfer)
    pattern = 4'b1101; repeat_cnt = 4'd2; gap_len = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("pre_reset_gap", {27'b0, obs()}, {27'b0, 5'b00100});
    #2 rst_n = 1'b0;
    #1 check_val("reset_async", {27'b0, obs()}, {27'b0, IDLE_V});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("reset_no_done", {27'b0, obs()}, {27'b0, IDLE_V});
    run_txn(4'b0110, 1, 0, 0, 1'b0, 1'b0);   // recovery

    // randomized transfers
    for (int n = 0; n < 40; n++) begin
      rp = PAT_W'($urandom);
      rr = $urandom_range(0, 4);
      rg = $urandom_range(0, 3);
      tot = (rr == 0) ? 1 : rr * PAT_W + (rr - 1) * rg + 1;
      ra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, tot) : 0;
      run_txn(rp, rr, rg, ra, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time limit
  initial begin
    #500000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter that drives serial inputs of the `seq_*` detector FSMs, MSB first, one bit per clock.
- Loads a PAT_W-bit pattern, a repeat count and an inter-repeat gap length through a start/ready handshake.
- Emits the pattern the requested number of times, then pulses done.
- Serves as on-chip stimulus source and loopback partner for the sequence detectors; all outputs are registered (glitch-free).

Parameters:
- PAT_W, 4, pattern length in bits (≥2).
- CNT_W, 4, width of repeat count.
- GAP_W, 4, width of gap length.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted on a rising edge when start=1, ready=1 and abort=0.
- pattern  input  PAT_W  bits to send; bit PAT_W-1 first; sampled only at acceptance.
- repeat_cnt  input  CNT_W  number of pattern repetitions; sampled at acceptance.
- gap_len  input  GAP_W  idle cycles between repetitions; sampled at acceptance.
- abort  input  1  synchronous cancel; acts on the sampling edge.
- ready  output  1  1 only in IDLE; decoded from state register.
- out  output  1  serial data bit (registered).
- out_valid  output  1  1 while out carries a pattern bit (registered).
- busy  output  1  1 in SEND or GAP (registered).
- done  output  1  single-cycle completion pulse (registered).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; out=0, out_valid=0, busy=0, done=0.
  - ready=1 while reset is held.
  - Internal pattern, repeat and gap registers cleared.
- States: IDLE, SEND, GAP, DONE. Two-bit state register, default branch → IDLE with all outputs 0.
- IDLE:
  - On accept edge, latch pattern/repeat_cnt/gap_len.
  - If repeat_cnt≠0:
    - Go to SEND.
    - At that same edge drive out=pattern[PAT_W-1], out_valid=1, busy=1.
    - First bit is therefore visible in the cycle immediately after acceptance (latency 1).
  - If repeat_cnt=0: go directly to DONE; no bits are sent.
- SEND:
  - One bit per cycle from a bit index counting PAT_W-1 down to 0.
  - After the last bit (index 0), decrement the remaining-repeat counter.
  - If the counter becomes 0 → DONE.
  - Else if the latched gap=0 → stay in SEND, reload index PAT_W-1 and send back-to-back with no bubble.
  - Else → GAP.
- GAP:
  - out=0, out_valid=0, busy=1 for exactly gap cycles, counted by a down-counter.
  - Then return to SEND with index PAT_W-1.
- DONE:
  - done=1, busy=0, out_valid=0, out=0 for exactly one cycle.
  - ready=0 in DONE.
  - Next state is always IDLE.
- out is forced to 0 whenever out_valid=0.
- Total cycles from acceptance to done:
  - done asserted in cycle R·PAT_W + (R−1)·G + 1 after the acceptance edge, for R≥1.
  - done asserted in cycle 1 for R=0.
- start while busy or in DONE is ignored; latched values are unaffected by input changes after acceptance.
- abort=1 at any edge in SEND or GAP:
  - Next state is IDLE; out=0, out_valid=0, busy=0.
  - done is NOT pulsed.
- abort=1 in IDLE blocks acceptance; abort wins over simultaneous start.
- abort in DONE: the done pulse completes normally.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Maximum repeat count is 2^CNT_W−1; counters never wrap during a transfer.

Test Plan:
- Single send: pattern=1101, repeat=1, gap=0, start 1 cycle → out_valid=1 for 4 cycles with out=1,1,0,1; done=1 in the 5th cycle after acceptance; ready=1 in the 6th.
- Back-to-back: pattern=1101, repeat=3, gap=0 → 12 contiguous valid bits 110111011101; a looped-back 1101 Mealy detector asserts op 3 times, on bits 4, 8 and 12; done in cycle 13.
- Gap: pattern=1101, repeat=2, gap=2 → 1101, then 2 cycles with out_valid=0/out=0, then 1101; done in cycle 11; busy=1 throughout cycles 1–10.
- Zero repeat and ignored start:
  - repeat=0 → no out_valid, done in cycle 1.
  - Re-asserting start with pattern=0000 during a pattern=1011 send leaves the bitstream unchanged.
- Abort: pattern=1101, repeat=2, gap=1, abort asserted at the 3rd bit → out_valid=0 and busy=0 from the next cycle, ready=1, done never pulses.
- Abort with simultaneous start in IDLE → no acceptance.
- Reset mid-operation: rst_n low for 1 cycle during GAP → out=0, out_valid=0, busy=0, done=0 asynchronously.
- Reset recovery: after release, a new start with pattern=0110 sends 0,1,1,0 correctly.
